// File: rtl/psum_acc_pkg.sv
// rtl/psum_acc_pkg.sv - shared state encoding, info-field layout and size defaults for psum_acc
package psum_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_P0    = 2'd1,
      ST_P1    = 2'd2,
      ST_DRAIN = 2'd3
   } acc_state_t;

   localparam int INFO_HALF_BIT = 13;
   localparam int INFO_PASS_BIT = 12;
   localparam int INFO_OFS_MSB  = 11;
   localparam int INFO_OFS_W    = INFO_OFS_MSB + 1;

   localparam int CH_W   = 6;
   localparam int ADDR_W = CH_W + INFO_OFS_W;

   localparam int DEF_MAP_SIZE = 3136;
   localparam int DEF_OUT_CH   = 64;

endpackage

// File: rtl/psum_acc_buf.sv
// rtl/psum_acc_buf.sv - simple dual-port psum buffer with one-cycle registered read
module psum_buf #(
   parameter int DEPTH = 3136,
   parameter int W     = 24,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   // No reset on storage: pass 0 always overwrites an entry before pass 1 reads it.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - two-pass partial-sum accumulator: buffer pass 0, add pass 1, shift, saturate
// Optional ReLU with unsigned saturation when PSUM_ACC_RELU_EN is defined.
module psum_acc
   import psum_acc_pkg::*;
#(
   parameter int PSUM_W   = 24,
   parameter int OUT_W    = 8,
   parameter int SHIFT    = 8,
   parameter int MAP_SIZE = DEF_MAP_SIZE,
   parameter int OUT_CH   = DEF_OUT_CH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              conv_start,
   input  logic              mac_array2psum_acc_vld,
   output logic              mac_array2psum_acc_rdy,
   input  logic [PSUM_W-1:0] mac_array2psum_acc_data,
   input  logic [31:0]       mac_array2psum_acc_info,
   output logic              psum_acc2omap_vld,
   input  logic              psum_acc2omap_rdy,
   output logic [OUT_W-1:0]  psum_acc2omap_data,
   output logic [17:0]       psum_acc2omap_addr,
   output logic              acc_done,
   output logic              acc_err
);

   localparam int AW = $clog2(MAP_SIZE);
   localparam logic [INFO_OFS_W-1:0] LAST_PIX = INFO_OFS_W'(MAP_SIZE - 1);
   localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(OUT_CH - 1);
`ifdef PSUM_ACC_RELU_EN
   localparam logic signed [PSUM_W:0] SAT_HI = (PSUM_W+1)'((2**OUT_W) - 1);
   localparam logic signed [PSUM_W:0] SAT_LO = '0;
`else
   localparam logic signed [PSUM_W:0] SAT_HI = (PSUM_W+1)'((2**(OUT_W-1)) - 1);
   localparam logic signed [PSUM_W:0] SAT_LO = (PSUM_W+1)'(-(2**(OUT_W-1)));
`endif

   acc_state_t r_state, w_state_nxt;

   logic [INFO_OFS_W-1:0] r_pix_cnt;
   logic [CH_W-1:0]       r_ch_cnt;
   logic                  r_err, r_done;

   logic                  r_s1_vld, r_s1_pass;
   logic [INFO_OFS_W-1:0] r_s1_ofs;
   logic [CH_W-1:0]       r_s1_ch;
   logic [PSUM_W-1:0]     r_s1_data;

   logic                  r_o_vld;
   logic [OUT_W-1:0]      r_o_data;
   logic [ADDR_W-1:0]     r_o_addr;

   logic                  w_en, w_in_run, w_rdy, w_acc, w_bad, w_pix_last, w_done;
   logic                  w_info_pass, w_info_half, w_exp_pass;
   logic [INFO_OFS_W-1:0] w_info_ofs;
   logic [PSUM_W-1:0]     w_rdata;
   logic signed [PSUM_W:0] w_sum, w_shr;
   logic [OUT_W-1:0]      w_res;

   assign w_info_ofs  = mac_array2psum_acc_info[INFO_OFS_MSB:0];
   assign w_info_pass = mac_array2psum_acc_info[INFO_PASS_BIT];
   assign w_info_half = mac_array2psum_acc_info[INFO_HALF_BIT];

   assign w_en       = !r_o_vld || psum_acc2omap_rdy;
   assign w_in_run   = (r_state == ST_P0) || (r_state == ST_P1);
   assign w_rdy      = w_in_run && w_en;
   // A beat arriving alongside a restart belongs to the abandoned convolution.
   assign w_acc      = mac_array2psum_acc_vld && w_rdy && !conv_start;
   assign w_pix_last = (r_pix_cnt == LAST_PIX);
   assign w_exp_pass = (r_state == ST_P1);
   assign w_bad      = (w_info_pass != w_exp_pass) || (w_info_ofs != r_pix_cnt)
                    || (w_info_half != r_ch_cnt[CH_W-1]);

   psum_buf #(
      .DEPTH (MAP_SIZE),
      .W     (PSUM_W),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_acc && !w_info_pass),
      .i_waddr (w_info_ofs[AW-1:0]),
      .i_wdata (mac_array2psum_acc_data),
      .i_re    (w_acc && w_info_pass),
      .i_raddr (w_info_ofs[AW-1:0]),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      if (conv_start) begin
         w_state_nxt = ST_P0;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_P0:    if (w_acc && w_pix_last) w_state_nxt = ST_P1;
            ST_P1:    if (w_acc && w_pix_last)
                         w_state_nxt = (r_ch_cnt == LAST_CH) ? ST_DRAIN : ST_P0;
            ST_DRAIN: if (!r_s1_vld && (!r_o_vld || psum_acc2omap_rdy)) begin
                         w_state_nxt = ST_IDLE;
                         w_done      = 1'b1;
                      end
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || conv_start) begin
         r_pix_cnt <= '0;
         r_ch_cnt  <= '0;
         r_err     <= 1'b0;
      end else if (w_acc) begin
         if (w_bad)
            r_err <= 1'b1;
         if (w_pix_last) begin
            r_pix_cnt <= '0;
            if (r_state == ST_P1)
               r_ch_cnt <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + CH_W'(1);
         end else begin
            r_pix_cnt <= r_pix_cnt + INFO_OFS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || conv_start) begin
         r_s1_vld <= 1'b0;
      end else if (w_en) begin
         r_s1_vld  <= w_acc;
         r_s1_pass <= w_info_pass;
         r_s1_ofs  <= w_info_ofs;
         r_s1_ch   <= r_ch_cnt;
         r_s1_data <= mac_array2psum_acc_data;
      end
   end

   // Extra bit keeps the sum of two full-scale partial sums from wrapping.
   assign w_sum = $signed({w_rdata[PSUM_W-1], w_rdata})
                + $signed({r_s1_data[PSUM_W-1], r_s1_data});
   assign w_shr = w_sum >>> SHIFT;

   always_comb begin
      w_res = w_shr[OUT_W-1:0];
      if (w_shr > SAT_HI)
         w_res = SAT_HI[OUT_W-1:0];
      else if (w_shr < SAT_LO)
         w_res = SAT_LO[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_o_vld  <= 1'b0;
         r_o_data <= '0;
         r_o_addr <= '0;
      end else if (conv_start) begin
         r_o_vld <= 1'b0;
      end else if (w_en) begin
         r_o_vld <= r_s1_vld && r_s1_pass;
         if (r_s1_vld && r_s1_pass) begin
            r_o_data <= w_res;
            r_o_addr <= {r_s1_ch, r_s1_ofs};
         end
      end
   end

   assign mac_array2psum_acc_rdy = w_rdy;
   assign psum_acc2omap_vld      = r_o_vld;
   assign psum_acc2omap_data     = r_o_data;
   assign psum_acc2omap_addr     = r_o_addr;
   assign acc_done               = r_done;
   assign acc_err                = r_err;

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - directed vector bench for psum_acc with scoreboard and corner sequences
module tb_psum_acc;
   import psum_acc_pkg::*;

   localparam int PSUM_W = 24;
   localparam int OUT_W  = 8;
   localparam int SHIFT  = 8;
   localparam int MAP    = 8;
   localparam int NCH    = 4;
`ifdef PSUM_ACC_RELU_EN
   localparam longint HI = 255;
   localparam longint LO = 0;
`else
   localparam longint HI = 127;
   localparam longint LO = -128;
`endif

   logic              clk = 1'b0;
   logic              rst, conv_start, in_vld, in_rdy, out_vld, out_rdy, acc_done, acc_err;
   logic [PSUM_W-1:0] in_data;
   logic [31:0]       in_info;
   logic [OUT_W-1:0]  out_data;
   logic [17:0]       out_addr;

   psum_acc #(
      .PSUM_W   (PSUM_W),
      .OUT_W    (OUT_W),
      .SHIFT    (SHIFT),
      .MAP_SIZE (MAP),
      .OUT_CH   (NCH)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .conv_start              (conv_start),
      .mac_array2psum_acc_vld  (in_vld),
      .mac_array2psum_acc_rdy  (in_rdy),
      .mac_array2psum_acc_data (in_data),
      .mac_array2psum_acc_info (in_info),
      .psum_acc2omap_vld       (out_vld),
      .psum_acc2omap_rdy       (out_rdy),
      .psum_acc2omap_data      (out_data),
      .psum_acc2omap_addr      (out_addr),
      .acc_done                (acc_done),
      .acc_err                 (acc_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic [17:0]      a;
   } out_t;

   typedef struct {
      int               p0;
      int               p1;
      logic [OUT_W-1:0] exp_s;
      logic [OUT_W-1:0] exp_r;
   } vec_t;

   out_t exp_q[$];
   int   n_checks = 0, n_errors = 0;
   int   n_out = 0, n_done = 0, done_cyc = 0, last_hs = 0, vld_rise = 0;
   logic [17:0] last_a = '0;
   bit   ignore_out = 0, rand_rdy = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [OUT_W-1:0] model(input int a, input int b);
      longint r;
      r = (longint'(a) + longint'(b)) >>> SHIFT;
      if (r > HI) r = HI;
      if (r < LO) r = LO;
      return r[OUT_W-1:0];
   endfunction

   // Output monitor: scoreboard, stall stability, back-pressure and done tracking.
   initial begin
      bit               stall_prev = 0, vld_prev = 0;
      logic [OUT_W-1:0] prev_d = '0;
      logic [17:0]      prev_a = '0;
      out_t             e;
      forever begin
         @(negedge clk);
         if (stall_prev) begin
            chk("stall vld held", out_vld, 1);
            chk("stall data held", out_data, prev_d);
            chk("stall addr held", out_addr, prev_a);
         end
         if (out_vld && !out_rdy)
            chk("input rdy low while output stalled", in_rdy, 0);
         if (!rst && out_vld && out_rdy) begin
            n_out++;
            last_hs = cyc;
            last_a  = out_addr;
            if (!ignore_out) begin
               chk("output expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk($sformatf("out data @%0h", e.a), out_data, e.d);
                  chk($sformatf("out addr @%0h", e.a), out_addr, e.a);
               end
            end
         end
         if (acc_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (out_vld && !vld_prev) vld_rise = cyc;
         vld_prev   = out_vld;
         stall_prev = out_vld && !out_rdy && !rst && !conv_start;
         prev_d     = out_data;
         prev_a     = out_addr;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      conv_start = 1'b1;
      tick();
      conv_start = 1'b0;
   endtask

   task automatic send_beat(input int d, input logic pass, input logic half, input int ofs,
                            output int waits, output int acc_cyc);
      in_vld  = 1'b1;
      in_data = PSUM_W'(d);
      in_info = {18'd0, half, pass, 12'(ofs)};
      waits   = 0;
      @(negedge clk);
      while (!in_rdy && waits < 300) begin
         waits++;
         @(negedge clk);
      end
      chk("beat accepted", in_rdy, 1);
      acc_cyc = cyc;
      tick();
      in_vld = 1'b0;
   endtask

   task automatic send_map(input logic pass, input int base, input int step,
                           output int waits, output int first_acc);
      int w, c;
      waits = 0;
      first_acc = 0;
      for (int off = 0; off < MAP; off++) begin
         send_beat(base + off * step, pass, 1'b0, off, w, c);
         waits += w;
         if (off == 0) first_acc = c;
      end
   endtask

   task automatic wait_drain(input string what);
      int n = 0;
      while ((exp_q.size() != 0 || out_vld) && n < 1000) begin
         tick();
         n++;
      end
      chk($sformatf("%s drained", what), exp_q.size(), 0);
   endtask

   initial begin
      vec_t vecs[11];
      int   w, fa, n, n0;
      logic [OUT_W-1:0] ev;

      vecs[0]  = '{1000,     24,       8'h04, 8'h04};
      vecs[1]  = '{100000,   0,        8'h7F, 8'hFF};
      vecs[2]  = '{-100000,  0,        8'h80, 8'h00};
      vecs[3]  = '{300,      -1000,    8'hFD, 8'h00};
      vecs[4]  = '{32512,    255,      8'h7F, 8'h7F};
      vecs[5]  = '{32768,    0,        8'h7F, 8'h80};
      vecs[6]  = '{-32768,   0,        8'h80, 8'h00};
      vecs[7]  = '{-32769,   0,        8'h80, 8'h00};
      vecs[8]  = '{65280,    255,      8'h7F, 8'hFF};
      vecs[9]  = '{8388607,  8388607,  8'h7F, 8'hFF};
      vecs[10] = '{-8388608, -8388608, 8'h80, 8'h00};

      rst = 1'b1; conv_start = 1'b0; in_vld = 1'b0; in_data = '0; in_info = '0; out_rdy = 1'b1;
      repeat (3) tick();
      chk("reset in_rdy", in_rdy, 0);
      chk("reset out_vld", out_vld, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_addr", out_addr, 0);
      chk("reset acc_done", acc_done, 0);
      chk("reset acc_err", acc_err, 0);
      chk("reset state", dut.r_state, ST_IDLE);
      rst = 1'b0;
      in_vld = 1'b1;
      tick();
      chk("idle in_rdy", in_rdy, 0);
      in_vld = 1'b0;

      for (int i = 0; i < 11; i++) begin
`ifdef PSUM_ACC_RELU_EN
         ev = vecs[i].exp_r;
`else
         ev = vecs[i].exp_s;
`endif
         pulse_start();
         send_map(1'b0, vecs[i].p0, 0, w, fa);
         for (int off = 0; off < MAP; off++) exp_q.push_back('{d: ev, a: {6'd0, 12'(off)}});
         send_map(1'b1, vecs[i].p1, 0, w, fa);
         chk($sformatf("vec%0d pass1 stalls", i), w, 0);
         wait_drain($sformatf("vec%0d", i));
         chk($sformatf("vec%0d latency", i), vld_rise, fa + 2);
         chk($sformatf("vec%0d acc_err", i), acc_err, 0);
      end

      rand_rdy = 1;
      n0 = n_out;
      pulse_start();
      send_map(1'b0, -2000, 700, w, fa);
      for (int off = 0; off < MAP; off++)
         exp_q.push_back('{d: model(-2000 + off * 700, 37 - off * 11), a: {6'd0, 12'(off)}});
      send_map(1'b1, 37, -11, w, fa);
      wait_drain("backpressure");
      chk("backpressure beat count", n_out - n0, MAP);

      n0 = n_out;
      n_done = 0;
      pulse_start();
      for (int ch = 0; ch < NCH; ch++) begin
         send_map(1'b0, ch * 5000 - 9000, 3001, w, fa);
         for (int off = 0; off < MAP; off++)
            exp_q.push_back('{d: model(ch * 5000 - 9000 + off * 3001, 50 - ch * 700 + off * 97),
                              a: {6'(ch), 12'(off)}});
         send_map(1'b1, 50 - ch * 700, 97, w, fa);
      end
      n = 0;
      while (n_done == 0 && n < 2000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      rand_rdy = 0;
      out_rdy = 1'b1;
      chk("full run beat count", n_out - n0, NCH * MAP);
      chk("full run last addr", last_a, {6'(NCH - 1), 12'(MAP - 1)});
      chk("full run done pulses", n_done, 1);
      chk("full run done timing", done_cyc, last_hs + 1);
      chk("full run state idle", dut.r_state, ST_IDLE);
      chk("full run acc_err", acc_err, 0);
      chk("full run queue empty", exp_q.size(), 0);

      ignore_out = 1;
      for (int k = 0; k < 3; k++) begin
         pulse_start();
         chk($sformatf("err kind%0d cleared by start", k), acc_err, 0);
         case (k)
            0:       send_beat(11, 1'b1, 1'b0, 0, w, fa);
            1:       send_beat(11, 1'b0, 1'b0, 3, w, fa);
            default: send_beat(11, 1'b0, 1'b1, 0, w, fa);
         endcase
         chk($sformatf("err kind%0d raised", k), acc_err, 1);
         send_beat(12, 1'b0, 1'b0, 1, w, fa);
         tick();
         chk($sformatf("err kind%0d sticky", k), acc_err, 1);
      end
      pulse_start();
      chk("err cleared by final start", acc_err, 0);

      exp_q.delete();
      pulse_start();
      send_map(1'b0, 5000, 0, w, fa);
      out_rdy = 1'b0;
      send_beat(0, 1'b1, 1'b0, 0, w, fa);
      send_beat(0, 1'b1, 1'b0, 1, w, fa);
      chk("pre-reset out_vld", out_vld, 1);
      chk("pre-reset state", dut.r_state, ST_P1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid reset out_vld", out_vld, 0);
      chk("mid reset out_data", out_data, 0);
      chk("mid reset out_addr", out_addr, 0);
      chk("mid reset acc_done", acc_done, 0);
      chk("mid reset acc_err", acc_err, 0);
      chk("mid reset in_rdy", in_rdy, 0);
      chk("mid reset state", dut.r_state, ST_IDLE);
      out_rdy = 1'b1;
      in_vld = 1'b1;
      in_info = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post reset no accept %0d", i), in_rdy, 0);
      end
      tick();
      in_vld = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
